// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map, idle column drive.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] COL_IDLE = 4'b1110;

  // Indexed {row[1:0], col[1:0]}; row 3 carries * (E), 0, # (F), D.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

  // Lowest-index low row wins when several rows are pulled down.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    for (int r = 3; r >= 0; r--) begin
      if (!rows[r]) idx = 2'(r);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; 2-cycle latency, resets to all-ones (idle pull-up level).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner with debounce; key_valid pulses DEBOUNCE_CYCLES+1 cycles after the detecting sample, no backpressure.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses every REPEAT_CYCLES while a key is held.
module keypad_scan_4x4 #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_CYCLES = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  import keypad_pkg::*;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  // The HELD cycle that first sees the row high counts toward the release window.
  localparam logic [DEB_W-1:0] REL_LAST = DEB_W'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);

  logic [3:0]       row_s;
  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic [DEB_W-1:0] deb_cnt, deb_d;
  logic [1:0]       col_idx, col_idx_d;
  logic [1:0]       row_lat, row_lat_d;
  logic [3:0]       col_d, code_d;
  logic             valid_d, held_d, release_done;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt, rep_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt <= '0;
    else        rep_cnt <= rep_d;
  end
`endif

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_in),
    .q     (row_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      col_idx   <= 2'd0;
      row_lat   <= 2'd0;
      col_out   <= COL_IDLE;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_d;
      div_cnt   <= div_d;
      deb_cnt   <= deb_d;
      col_idx   <= col_idx_d;
      row_lat   <= row_lat_d;
      col_out   <= col_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      key_held  <= held_d;
    end
  end

  always_comb begin
    state_d      = state;
    div_d        = div_cnt;
    deb_d        = deb_cnt;
    col_idx_d    = col_idx;
    row_lat_d    = row_lat;
    col_d        = col_out;
    code_d       = key_code;
    valid_d      = 1'b0;
    held_d       = key_held;
    release_done = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d        = '0;
`endif

    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_d = '0;
          if (row_s != 4'hF) begin
            row_lat_d = low_row(row_s);
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx + 2'd1;
            col_d     = {col_out[2:0], col_out[3]};
          end
        end else begin
          div_d = div_cnt + DIV_W'(1);
        end
      end

      DEBOUNCE: begin
        if (!row_s[row_lat]) begin
          if (deb_cnt == DEB_LAST) begin
            valid_d = 1'b1;
            code_d  = key_lookup(row_lat, col_idx);
            held_d  = 1'b1;
            deb_d   = '0;
            state_d = HELD;
          end else begin
            deb_d = deb_cnt + DEB_W'(1);
          end
        end else begin
          // Bounce: retry the same column on the next full scan period.
          deb_d   = '0;
          state_d = SCAN;
        end
      end

      HELD: begin
        if (row_s[row_lat]) begin
          if (DEBOUNCE_CYCLES == 1) begin
            release_done = 1'b1;
          end else begin
            deb_d   = '0;
            state_d = RELEASE;
          end
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_cnt == REP_LAST) begin
          valid_d = 1'b1;
        end else begin
          rep_d = rep_cnt + REP_W'(1);
        end
`endif
      end

      RELEASE: begin
        if (row_s[row_lat]) begin
          if (deb_cnt == REL_LAST) release_done = 1'b1;
          else                     deb_d = deb_cnt + DEB_W'(1);
        end else begin
          deb_d   = '0;
          state_d = HELD;
        end
      end

      default: state_d = SCAN;
    endcase

    if (release_done) begin
      held_d    = 1'b0;
      state_d   = SCAN;
      div_d     = '0;
      deb_d     = '0;
      col_idx_d = col_idx + 2'd1;
      col_d     = {col_out[2:0], col_out[3]};
    end
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32); cycle 0 is the negedge of reset release.
module tb_keypad_scan_4x4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;   // bit r*4+c set = key at row r, column c pressed

  int vectors = 0;
  int errors  = 0;

  logic [3:0] scan_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scan_4x4 #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_CYCLES (32)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a row is pulled low when a pressed key sits on the driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic start_run(input logic [15:0] k);
    keys = k;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    keys  = 16'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b exp=1110", col_out); end
    vectors++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got=%h exp=0", key_code); end
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got=%b exp=0", key_held); end
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      vectors++; if (col_out !== scan_pat[(cyc/4)%4]) begin errors++; $display("FAIL idle_scan cyc=%0d got=%b exp=%b", cyc, col_out, scan_pat[(cyc/4)%4]); end
      vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", cyc, key_valid); end
      vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL idle_held cyc=%0d got=%b exp=0", cyc, key_held); end
    end
  endtask

  // "5" detected by the sample at cycle 7, accepted at cycle 16.
  task automatic test_single_press();
    int pulses = 0;
    start_run(16'h0020);
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (key_valid === 1'b1) pulses++;
      vectors++; if (key_valid !== (cyc == 16)) begin errors++; $display("FAIL press5_valid cyc=%0d got=%b exp=%b", cyc, key_valid, cyc == 16); end
      vectors++; if (key_held !== (cyc >= 16)) begin errors++; $display("FAIL press5_held cyc=%0d got=%b exp=%b", cyc, key_held, cyc >= 16); end
      if (cyc >= 4) begin
        vectors++; if (col_out !== 4'b1101) begin errors++; $display("FAIL press5_col cyc=%0d got=%b exp=1101", cyc, col_out); end
      end
      if (cyc >= 16) begin
        vectors++; if (key_code !== 4'h5) begin errors++; $display("FAIL press5_code cyc=%0d got=%h exp=5", cyc, key_code); end
      end
    end
    vectors++; if (pulses != 1) begin errors++; $display("FAIL press5_pulses got=%0d exp=1", pulses); end
  endtask

  // "0" bounces high for one cycle after 5 debounce cycles; retry samples at 17, accepts at 26.
  task automatic test_press_bounce();
    start_run(16'h2000);
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      vectors++; if (key_valid !== (cyc == 26)) begin errors++; $display("FAIL bounce_valid cyc=%0d got=%b exp=%b", cyc, key_valid, cyc == 26); end
      vectors++; if (key_held !== (cyc >= 26)) begin errors++; $display("FAIL bounce_held cyc=%0d got=%b exp=%b", cyc, key_held, cyc >= 26); end
      if (cyc >= 4) begin
        vectors++; if (col_out !== 4'b1101) begin errors++; $display("FAIL bounce_col cyc=%0d got=%b exp=1101", cyc, col_out); end
      end
      if (cyc == 26) begin
        vectors++; if (key_code !== 4'h0) begin errors++; $display("FAIL bounce_code got=%h exp=0", key_code); end
      end
      if (cyc == 11) keys = 16'h0000;
      if (cyc == 12) keys = 16'h2000;
    end
  endtask

  // "#" accepted at 20; synchronised row high 32-34, low 35-36, high from 37; held falls at 45.
  task automatic test_release_bounce();
    logic [3:0] exp_col;
    start_run(16'h4000);
    for (int cyc = 0; cyc <= 52; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc < 8)       exp_col = scan_pat[cyc/4];
      else if (cyc < 45) exp_col = 4'b1011;
      else if (cyc < 49) exp_col = 4'b0111;
      else               exp_col = 4'b1110;
      vectors++; if (col_out !== exp_col) begin errors++; $display("FAIL release_col cyc=%0d got=%b exp=%b", cyc, col_out, exp_col); end
      vectors++; if (key_valid !== (cyc == 20)) begin errors++; $display("FAIL release_valid cyc=%0d got=%b exp=%b", cyc, key_valid, cyc == 20); end
      vectors++; if (key_held !== (cyc >= 20 && cyc < 45)) begin errors++; $display("FAIL release_held cyc=%0d got=%b exp=%b", cyc, key_held, cyc >= 20 && cyc < 45); end
      if (cyc >= 20) begin
        vectors++; if (key_code !== 4'hF) begin errors++; $display("FAIL release_code cyc=%0d got=%h exp=F", cyc, key_code); end
      end
      if (cyc == 30) keys = 16'h0000;
      if (cyc == 33) keys = 16'h4000;
      if (cyc == 35) keys = 16'h0000;
    end
  endtask

  // r0/c3 ("A") and r2/c3 ("C") together: sample at 15, accept at 24 with the lower row.
  task automatic test_row_priority();
    start_run(16'h0808);
    for (int cyc = 0; cyc <= 30; cyc++) begin
      if (cyc > 0) @(negedge clk);
      vectors++; if (key_valid !== (cyc == 24)) begin errors++; $display("FAIL prio_valid cyc=%0d got=%b exp=%b", cyc, key_valid, cyc == 24); end
      if (cyc >= 24) begin
        vectors++; if (key_code !== 4'hA) begin errors++; $display("FAIL prio_code cyc=%0d got=%h exp=A", cyc, key_code); end
        vectors++; if (key_held !== 1'b1) begin errors++; $display("FAIL prio_held cyc=%0d got=%b exp=1", cyc, key_held); end
      end
    end
  endtask

  // "5" accepted at 16, swapped for "9" at 20; release done at 30, "9" in DEBOUNCE from 34 when reset hits.
  task automatic test_reset_in_debounce();
    start_run(16'h0020);
    for (int cyc = 0; cyc <= 36; cyc++) begin
      if (cyc > 0) @(negedge clk);
      vectors++; if (key_valid !== (cyc == 16)) begin errors++; $display("FAIL rstdeb_valid cyc=%0d got=%b exp=%b", cyc, key_valid, cyc == 16); end
      vectors++; if (key_held !== (cyc >= 16 && cyc < 30)) begin errors++; $display("FAIL rstdeb_held cyc=%0d got=%b exp=%b", cyc, key_held, cyc >= 16 && cyc < 30); end
      if (cyc == 20) keys = 16'h0400;
      if (cyc == 35) begin
        vectors++; if (col_out !== 4'b1011) begin errors++; $display("FAIL rstdeb_frozen_col got=%b exp=1011", col_out); end
        vectors++; if (key_code !== 4'h5) begin errors++; $display("FAIL rstdeb_code_before got=%h exp=5", key_code); end
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++; if (col_out !== 4'b1110) begin errors++; $display("FAIL rstdeb_col got=%b exp=1110", col_out); end
    vectors++; if (key_code !== 4'h0) begin errors++; $display("FAIL rstdeb_code got=%h exp=0", key_code); end
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstdeb_valid_rst got=%b exp=0", key_valid); end
    vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL rstdeb_held_rst got=%b exp=0", key_held); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc <= 22; cyc++) begin
      if (cyc > 0) @(negedge clk);
      vectors++; if (key_valid !== (cyc == 20)) begin errors++; $display("FAIL refresh_valid cyc=%0d got=%b exp=%b", cyc, key_valid, cyc == 20); end
      if (cyc == 20) begin
        vectors++; if (key_code !== 4'h9) begin errors++; $display("FAIL refresh_code got=%h exp=9", key_code); end
      end
    end
  endtask

`ifdef KEYPAD_REPEAT_EN
  // "9" accepted at 20, repeats at 52, 84, 116.
  task automatic test_repeat();
    int pulses = 0;
    logic exp_v;
    start_run(16'h0400);
    for (int cyc = 0; cyc <= 120; cyc++) begin
      if (cyc > 0) @(negedge clk);
      exp_v = (cyc == 20) || (cyc == 52) || (cyc == 84) || (cyc == 116);
      if (cyc > 20 && key_valid === 1'b1) pulses++;
      vectors++; if (key_valid !== exp_v) begin errors++; $display("FAIL repeat_valid cyc=%0d got=%b exp=%b", cyc, key_valid, exp_v); end
      if (cyc >= 20) begin
        vectors++; if (key_code !== 4'h9) begin errors++; $display("FAIL repeat_code cyc=%0d got=%h exp=9", cyc, key_code); end
      end
    end
    vectors++; if (pulses != 3) begin errors++; $display("FAIL repeat_pulses got=%0d exp=3", pulses); end
  endtask
`else
  // Without auto-repeat a held "9" yields exactly one pulse.
  task automatic test_repeat();
    int pulses = 0;
    start_run(16'h0400);
    for (int cyc = 0; cyc <= 120; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (key_valid === 1'b1) pulses++;
      vectors++; if (key_valid !== (cyc == 20)) begin errors++; $display("FAIL norepeat_valid cyc=%0d got=%b exp=%b", cyc, key_valid, cyc == 20); end
    end
    vectors++; if (pulses != 1) begin errors++; $display("FAIL norepeat_pulses got=%0d exp=1", pulses); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    keys  = 16'h0;
    test_reset();
    test_single_press();
    test_press_bounce();
    test_release_bounce();
    test_row_priority();
    test_reset_in_debounce();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
